roce_tx_header_segmenter: RTL and testbench
===========================================

Name: roce_tx_header_segmenter

Overview:
Sits directly downstream of the work-queue stage, consuming its per-work-request DMA metadata (length, QPNs, PSN, R_Key, remote address, immediate, transfer type). Splits each request into PMTU-sized packets and emits one header-metadata beat per packet: BTH opcode, PSN, payload length, and RETH/ImmDt fields. Also emits a PSN-update beat back to the QP context.

Parameters:
PSN_WIDTH, 24, PSN/QPN field width; fixed by IB BTH format, not to be changed.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_pmtu  in  3  IB PMTU code, sampled at request accept: 1=256, 2=512, 3=1024, 4=2048, 5=4096; 0/6/7 treated as 256
s_dma_meta_valid/ready  in/out  1/1  request handshake
s_dma_length  in  32  total payload bytes
s_rem_qpn, s_loc_qpn, s_rem_psn  in  24 each  QP numbers and starting PSN
s_r_key  in  32;  s_rem_ip_addr  in  32;  s_rem_addr  in  64
s_is_immediate  in  1;  s_immediate_data  in  32
s_transfer_type  in  1  0=RDMA WRITE, 1=SEND
m_hdr_valid/ready  out/in  1/1  per-packet header handshake
m_hdr_opcode  out  8  BTH opcode
m_hdr_psn  out  24;  m_hdr_rem_qpn  out  24;  m_hdr_rem_ip_addr  out  32
m_hdr_ack_req  out  1  BTH AckReq bit
m_hdr_has_reth  out  1;  m_hdr_rem_addr  out  64;  m_hdr_r_key  out  32;  m_hdr_dma_length  out  32  RETH fields
m_hdr_has_imm  out  1;  m_hdr_immediate_data  out  32
m_hdr_payload_length  out  13  payload bytes in this packet
m_hdr_last  out  1  last packet of request
m_psn_upd_valid  out  1  one-cycle pulse
m_psn_upd_loc_qpn  out  24;  m_psn_upd_next_psn  out  24

Behaviour:
- States: IDLE, SEGMENT, WAIT_LAST. Reset: state IDLE, s_dma_meta_ready=0 for one cycle, then 1 in IDLE; m_hdr_valid=0, m_psn_upd_valid=0, all data outputs 0.
- s_dma_meta_ready=1 only in IDLE with m_hdr_valid=0. On accept: latch all inputs, pmtu_bytes, remaining=s_dma_length, psn=s_rem_psn, first=1; go to SEGMENT.
- SEGMENT: when output register empty or m_hdr_ready=1, load next header; m_hdr_valid=1 the cycle after accept (1-cycle latency), then one header per cycle under continuous ready. Payload = min(remaining, pmtu_bytes); remaining -= payload; psn += 1 mod 2^24.
- Opcodes: only = first && remaining<=pmtu. WRITE: FIRST 0x06, MIDDLE 0x07, LAST 0x08, LAST_IMM 0x09, ONLY 0x0A, ONLY_IMM 0x0B. SEND: FIRST 0x00, MIDDLE 0x01, LAST 0x02, LAST_IMM 0x03, ONLY 0x04, ONLY_IMM 0x05. _IMM variants only if is_immediate.
- has_reth=1 on WRITE FIRST/ONLY only; rem_addr/r_key/dma_length driven only then (else 0). has_imm=1 only on *_IMM opcodes.
- ack_req=1 on last packet only. m_hdr_last=1 with ONLY/LAST.
- Zero length: single ONLY packet, payload 0, PSN consumed (next = start+1).
- After loading the last header go to WAIT_LAST; when it is accepted (valid&&ready), pulse m_psn_upd_valid one cycle with loc_qpn and next_psn = start + packet count mod 2^24; return to IDLE.
- Output data held stable while m_hdr_valid && !m_hdr_ready.
- PSN wrap: 0xFFFFFF increments to 0x000000.
- Reset mid-request: request dropped, no PSN update, outputs to reset values next cycle.

Optional Feature:
ROCE_ACK_REQ_EVERY_PKT_EN: defined -> m_hdr_ack_req=1 on every packet. Undefined -> ack_req=1 only on last/only packet.

Test Plan:
- WRITE len=4096, pmtu=3, psn=0x000010 -> 4 hdrs opcodes 06,07,07,08, PSN 0x10..0x13, payload 1024 each, has_reth only on first; psn_upd next=0x14.
- SEND imm len=100, pmtu=1 -> one hdr opcode 0x05, payload 100, has_imm=1, ack_req=1, last=1.
- WRITE len=0 -> opcode 0x0A, payload 0, has_reth=1, dma_length=0; next_psn=start+1.
- WRITE len=600, pmtu=1, psn=0xFFFFFF -> payloads 256,256,88; PSN 0xFFFFFF,0x000000,0x000001; next_psn=0x000002.
- len=3000, pmtu=5, m_hdr_ready toggled randomly -> single ONLY hdr held stable while stalled; s_dma_meta_ready=0 until psn_upd pulse.
- rst asserted after 2nd of 4 packets -> m_hdr_valid=0 next cycle, no psn_upd pulse; new request then segments correctly.

Source files
------------

// File: rtl/roce_tx_header_segmenter_if.sv
// Bundle of the request-side and header-side handshakes of the RoCE TX
// header segmenter, plus the PSN-update return path to the QP context.
// slave  : the segmenter's own view (consumes requests, produces headers).
// master : the surrounding environment (produces requests, sinks headers).
interface roce_tx_header_segmenter_if #(
    parameter int PSN_WIDTH = 24
);
    // Request handshake: a request moves when s_dma_meta_valid && s_dma_meta_ready
    // are both high on a rising clock edge; the producer holds all s_* fields
    // stable while valid is high and ready is low. Header handshake follows
    // the same rule with m_hdr_valid/m_hdr_ready. m_psn_upd_valid is a
    // one-cycle pulse with no back-pressure.
    logic                 s_dma_meta_valid;
    logic                 s_dma_meta_ready;
    logic [31:0]          s_dma_length;
    logic [PSN_WIDTH-1:0] s_rem_qpn;
    logic [PSN_WIDTH-1:0] s_loc_qpn;
    logic [PSN_WIDTH-1:0] s_rem_psn;
    logic [31:0]          s_r_key;
    logic [31:0]          s_rem_ip_addr;
    logic [63:0]          s_rem_addr;
    logic                 s_is_immediate;
    logic [31:0]          s_immediate_data;
    logic                 s_transfer_type;

    logic                 m_hdr_valid;
    logic                 m_hdr_ready;
    logic [7:0]           m_hdr_opcode;
    logic [PSN_WIDTH-1:0] m_hdr_psn;
    logic [PSN_WIDTH-1:0] m_hdr_rem_qpn;
    logic [31:0]          m_hdr_rem_ip_addr;
    logic                 m_hdr_ack_req;
    logic                 m_hdr_has_reth;
    logic [63:0]          m_hdr_rem_addr;
    logic [31:0]          m_hdr_r_key;
    logic [31:0]          m_hdr_dma_length;
    logic                 m_hdr_has_imm;
    logic [31:0]          m_hdr_immediate_data;
    logic [12:0]          m_hdr_payload_length;
    logic                 m_hdr_last;

    logic                 m_psn_upd_valid;
    logic [PSN_WIDTH-1:0] m_psn_upd_loc_qpn;
    logic [PSN_WIDTH-1:0] m_psn_upd_next_psn;

    modport slave (
        input  s_dma_meta_valid, s_dma_length, s_rem_qpn, s_loc_qpn, s_rem_psn,
               s_r_key, s_rem_ip_addr, s_rem_addr, s_is_immediate,
               s_immediate_data, s_transfer_type, m_hdr_ready,
        output s_dma_meta_ready, m_hdr_valid, m_hdr_opcode, m_hdr_psn,
               m_hdr_rem_qpn, m_hdr_rem_ip_addr, m_hdr_ack_req, m_hdr_has_reth,
               m_hdr_rem_addr, m_hdr_r_key, m_hdr_dma_length, m_hdr_has_imm,
               m_hdr_immediate_data, m_hdr_payload_length, m_hdr_last,
               m_psn_upd_valid, m_psn_upd_loc_qpn, m_psn_upd_next_psn
    );

    modport master (
        output s_dma_meta_valid, s_dma_length, s_rem_qpn, s_loc_qpn, s_rem_psn,
               s_r_key, s_rem_ip_addr, s_rem_addr, s_is_immediate,
               s_immediate_data, s_transfer_type, m_hdr_ready,
        input  s_dma_meta_ready, m_hdr_valid, m_hdr_opcode, m_hdr_psn,
               m_hdr_rem_qpn, m_hdr_rem_ip_addr, m_hdr_ack_req, m_hdr_has_reth,
               m_hdr_rem_addr, m_hdr_r_key, m_hdr_dma_length, m_hdr_has_imm,
               m_hdr_immediate_data, m_hdr_payload_length, m_hdr_last,
               m_psn_upd_valid, m_psn_upd_loc_qpn, m_psn_upd_next_psn
    );
endinterface

// File: rtl/roce_tx_header_segmenter.sv
// RoCE TX header segmenter: splits one DMA work request into PMTU-sized
// packets and emits one BTH/RETH/ImmDt header beat per packet, followed by
// a PSN-update pulse for the QP context once the last header is taken.
// Optional build macro: ROCE_ACK_REQ_EVERY_PKT_EN sets AckReq on every
// packet instead of only on the last one.
module roce_tx_header_segmenter #(
    parameter int PSN_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    cfg_pmtu,
    roce_tx_header_segmenter_if.slave     bus,
    output logic [1:0]                    o_dbg_state
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEGMENT   = 2'd1,
        WAIT_LAST = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    // Request context carried across packets
    logic                 r_init_done;
    logic [31:0]          r_remaining;
    logic [PSN_WIDTH-1:0] r_psn;
    logic [12:0]          r_pmtu_bytes;
    logic                 r_is_write, r_is_imm;
    logic [PSN_WIDTH-1:0] r_rem_qpn, r_loc_qpn;
    logic [31:0]          r_rem_ip, r_imm_data;

    // Header output register
    logic                 r_hdr_valid, r_hdr_ack_req, r_hdr_has_reth, r_hdr_has_imm, r_hdr_last;
    logic [7:0]           r_hdr_opcode;
    logic [PSN_WIDTH-1:0] r_hdr_psn, r_hdr_rem_qpn;
    logic [31:0]          r_hdr_rem_ip, r_hdr_r_key, r_hdr_dma_length, r_hdr_imm;
    logic [63:0]          r_hdr_rem_addr;
    logic [12:0]          r_hdr_payload;
    logic                 r_upd_valid;
    logic [PSN_WIDTH-1:0] r_upd_qpn, r_upd_psn;

    logic                 w_meta_ready, w_accept, w_load, w_hdr_done;
    logic                 w_first, w_last, w_src_write, w_src_imm, w_has_reth, w_has_imm, w_ack_req;
    logic [31:0]          w_src_rem, w_src_ip, w_src_imm_data;
    logic [PSN_WIDTH-1:0] w_src_psn, w_src_rem_qpn;
    logic [12:0]          w_src_pmtu, w_payload, w_cfg_pmtu_bytes;
    logic [2:0]           w_op_off;
    logic [7:0]           w_opcode;

    assign w_meta_ready = (r_state == IDLE) && !r_hdr_valid && r_init_done;
    assign w_accept     = bus.s_dma_meta_valid && w_meta_ready;
    assign w_load       = w_accept || ((r_state == SEGMENT) && (!r_hdr_valid || bus.m_hdr_ready));
    assign w_hdr_done   = (r_state == WAIT_LAST) && r_hdr_valid && bus.m_hdr_ready;
    // The first packet is always built in the accept cycle straight from the
    // request inputs, so "first" is exactly the accept strobe.
    assign w_first      = w_accept;

    // Decode the PMTU code into bytes; unknown codes fall back to 256
    always_comb begin
        w_cfg_pmtu_bytes = 13'd256;
        case (cfg_pmtu)
            3'd2:    w_cfg_pmtu_bytes = 13'd512;
            3'd3:    w_cfg_pmtu_bytes = 13'd1024;
            3'd4:    w_cfg_pmtu_bytes = 13'd2048;
            3'd5:    w_cfg_pmtu_bytes = 13'd4096;
            default: w_cfg_pmtu_bytes = 13'd256;
        endcase
    end

    // Select packet source: live request inputs on accept, latched context otherwise
    always_comb begin
        w_src_rem      = r_remaining;
        w_src_psn      = r_psn;
        w_src_pmtu     = r_pmtu_bytes;
        w_src_write    = r_is_write;
        w_src_imm      = r_is_imm;
        w_src_rem_qpn  = r_rem_qpn;
        w_src_ip       = r_rem_ip;
        w_src_imm_data = r_imm_data;
        if (w_accept) begin
            w_src_rem      = bus.s_dma_length;
            w_src_psn      = bus.s_rem_psn;
            w_src_pmtu     = w_cfg_pmtu_bytes;
            w_src_write    = !bus.s_transfer_type;
            w_src_imm      = bus.s_is_immediate;
            w_src_rem_qpn  = bus.s_rem_qpn;
            w_src_ip       = bus.s_rem_ip_addr;
            w_src_imm_data = bus.s_immediate_data;
        end
    end

    // Build the next header: size, opcode and extended-header flags
    always_comb begin
        w_last    = (w_src_rem <= {19'd0, w_src_pmtu});
        w_payload = w_last ? w_src_rem[12:0] : w_src_pmtu;
        case ({w_first, w_last})
            2'b10:   w_op_off = 3'd0;                       // FIRST
            2'b00:   w_op_off = 3'd1;                       // MIDDLE
            2'b01:   w_op_off = w_src_imm ? 3'd3 : 3'd2;    // LAST / LAST_IMM
            default: w_op_off = w_src_imm ? 3'd5 : 3'd4;    // ONLY / ONLY_IMM
        endcase
        w_opcode   = (w_src_write ? 8'h06 : 8'h00) + {5'd0, w_op_off};
        w_has_reth = w_src_write && w_first;
        w_has_imm  = w_src_imm && w_last;
`ifdef ROCE_ACK_REQ_EVERY_PKT_EN
        w_ack_req  = 1'b1;
`else
        w_ack_req  = w_last;
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state: stay in SEGMENT until the last header is loaded
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_accept)          w_state_next = w_last ? WAIT_LAST : SEGMENT;
            SEGMENT:   if (w_load && w_last)  w_state_next = WAIT_LAST;
            WAIT_LAST: if (w_hdr_done)        w_state_next = IDLE;
            default:                          w_state_next = IDLE;
        endcase
    end

    // Datapath: latch request context, load header register, emit PSN update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_done      <= 1'b0;
            r_remaining      <= '0;
            r_psn            <= '0;
            r_pmtu_bytes     <= '0;
            r_is_write       <= 1'b0;
            r_is_imm         <= 1'b0;
            r_rem_qpn        <= '0;
            r_loc_qpn        <= '0;
            r_rem_ip         <= '0;
            r_imm_data       <= '0;
            r_hdr_valid      <= 1'b0;
            r_hdr_opcode     <= '0;
            r_hdr_psn        <= '0;
            r_hdr_rem_qpn    <= '0;
            r_hdr_rem_ip     <= '0;
            r_hdr_ack_req    <= 1'b0;
            r_hdr_has_reth   <= 1'b0;
            r_hdr_rem_addr   <= '0;
            r_hdr_r_key      <= '0;
            r_hdr_dma_length <= '0;
            r_hdr_has_imm    <= 1'b0;
            r_hdr_imm        <= '0;
            r_hdr_payload    <= '0;
            r_hdr_last       <= 1'b0;
            r_upd_valid      <= 1'b0;
            r_upd_qpn        <= '0;
            r_upd_psn        <= '0;
        end else begin
            r_init_done <= 1'b1;
            r_upd_valid <= 1'b0;
            if (w_accept) begin
                r_pmtu_bytes <= w_cfg_pmtu_bytes;
                r_is_write   <= !bus.s_transfer_type;
                r_is_imm     <= bus.s_is_immediate;
                r_rem_qpn    <= bus.s_rem_qpn;
                r_loc_qpn    <= bus.s_loc_qpn;
                r_rem_ip     <= bus.s_rem_ip_addr;
                r_imm_data   <= bus.s_immediate_data;
            end
            if (w_load) begin
                r_remaining      <= w_src_rem - {19'd0, w_payload};
                r_psn            <= w_src_psn + {{(PSN_WIDTH-1){1'b0}}, 1'b1};
                r_hdr_valid      <= 1'b1;
                r_hdr_opcode     <= w_opcode;
                r_hdr_psn        <= w_src_psn;
                r_hdr_rem_qpn    <= w_src_rem_qpn;
                r_hdr_rem_ip     <= w_src_ip;
                r_hdr_ack_req    <= w_ack_req;
                r_hdr_has_reth   <= w_has_reth;
                r_hdr_rem_addr   <= w_has_reth ? bus.s_rem_addr : 64'd0;
                r_hdr_r_key      <= w_has_reth ? bus.s_r_key : 32'd0;
                r_hdr_dma_length <= w_has_reth ? bus.s_dma_length : 32'd0;
                r_hdr_has_imm    <= w_has_imm;
                r_hdr_imm        <= w_has_imm ? w_src_imm_data : 32'd0;
                r_hdr_payload    <= w_payload;
                r_hdr_last       <= w_last;
            end else if (r_hdr_valid && bus.m_hdr_ready) begin
                r_hdr_valid <= 1'b0;
            end
            // r_psn already points one past the last packet's PSN here
            if (w_hdr_done) begin
                r_upd_valid <= 1'b1;
                r_upd_qpn   <= r_loc_qpn;
                r_upd_psn   <= r_psn;
            end
        end
    end

    assign bus.s_dma_meta_ready     = w_meta_ready;
    assign bus.m_hdr_valid          = r_hdr_valid;
    assign bus.m_hdr_opcode         = r_hdr_opcode;
    assign bus.m_hdr_psn            = r_hdr_psn;
    assign bus.m_hdr_rem_qpn        = r_hdr_rem_qpn;
    assign bus.m_hdr_rem_ip_addr    = r_hdr_rem_ip;
    assign bus.m_hdr_ack_req        = r_hdr_ack_req;
    assign bus.m_hdr_has_reth       = r_hdr_has_reth;
    assign bus.m_hdr_rem_addr       = r_hdr_rem_addr;
    assign bus.m_hdr_r_key          = r_hdr_r_key;
    assign bus.m_hdr_dma_length     = r_hdr_dma_length;
    assign bus.m_hdr_has_imm        = r_hdr_has_imm;
    assign bus.m_hdr_immediate_data = r_hdr_imm;
    assign bus.m_hdr_payload_length = r_hdr_payload;
    assign bus.m_hdr_last           = r_hdr_last;
    assign bus.m_psn_upd_valid      = r_upd_valid;
    assign bus.m_psn_upd_loc_qpn    = r_upd_qpn;
    assign bus.m_psn_upd_next_psn   = r_upd_psn;
    assign o_dbg_state              = r_state;
endmodule

// File: tb/tb_roce_tx_header_segmenter.sv
// Bench for roce_tx_header_segmenter: directed and random work requests,
// a per-request packet-list reference model and a header/PSN-update scoreboard.
module tb_roce_tx_header_segmenter;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cfg_pmtu;
  logic [1:0] dbg_state;

  roce_tx_header_segmenter_if bus ();

  roce_tx_header_segmenter dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_pmtu    (cfg_pmtu),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] psn;
    logic [12:0] payload;
    logic        last;
    logic        ack_req;
    logic        has_reth;
    logic        has_imm;
    logic [63:0] rem_addr;
    logic [31:0] r_key;
    logic [31:0] dma_length;
    logic [31:0] imm;
    logic [23:0] rem_qpn;
    logic [31:0] rem_ip;
  } hdr_t;

  hdr_t        exp_q[$];
  logic [47:0] exp_upd_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int hdr_seen = 0;
  int ready_pct = 100;
  bit mon_en = 0;
  bit busy = 0;
  bit prev_stall = 0;
  hdr_t prev_hdr, cur_hdr, mon_e;
  logic [47:0] mon_u;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint pmtu_of(input logic [2:0] code);
    case (code)
      3'd2:    return 512;
      3'd3:    return 1024;
      3'd4:    return 2048;
      3'd5:    return 4096;
      default: return 256;
    endcase
  endfunction

  // Reference: the request becomes n = ceil(len/pmtu) packets (at least one),
  // all full-size except the tail; opcodes from the IB position table.
  task automatic model_request(input logic is_send, input logic imm, input logic [31:0] len,
                               input logic [2:0] code, input logic [23:0] psn0,
                               input logic [23:0] rqpn, input logic [23:0] lqpn,
                               input logic [31:0] rkey, input logic [31:0] ip,
                               input logic [31:0] imm_data, input logic [63:0] addr);
    longint p;
    longint n;
    hdr_t   h;
    logic [7:0] send_ops [6];
    logic [7:0] write_ops [6];
    send_ops  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    write_ops = '{8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    p = pmtu_of(code);
    n = (len == 0) ? 1 : (longint'(len) + p - 1) / p;
    for (longint k = 0; k < n; k++) begin
      bit is_first;
      bit is_last;
      int idx;
      is_first = (k == 0);
      is_last  = (k == n - 1);
      if (is_first && is_last) idx = imm ? 5 : 4;
      else if (is_first)       idx = 0;
      else if (is_last)        idx = imm ? 3 : 2;
      else                     idx = 1;
      h = '0;
      h.opcode  = is_send ? send_ops[idx] : write_ops[idx];
      h.psn     = 24'(longint'(psn0) + k);
      h.payload = 13'(is_last ? (longint'(len) - (n - 1) * p) : p);
      h.last    = is_last;
`ifdef ROCE_ACK_REQ_EVERY_PKT_EN
      h.ack_req = 1'b1;
`else
      h.ack_req = is_last;
`endif
      h.has_reth = !is_send && is_first;
      if (h.has_reth) begin
        h.rem_addr   = addr;
        h.r_key      = rkey;
        h.dma_length = len;
      end
      h.has_imm = imm && is_last;
      if (h.has_imm) h.imm = imm_data;
      h.rem_qpn = rqpn;
      h.rem_ip  = ip;
      exp_q.push_back(h);
    end
    exp_upd_q.push_back({lqpn, 24'(longint'(psn0) + n)});
  endtask

  function automatic hdr_t observe();
    hdr_t o;
    o.opcode     = bus.m_hdr_opcode;
    o.psn        = bus.m_hdr_psn;
    o.payload    = bus.m_hdr_payload_length;
    o.last       = bus.m_hdr_last;
    o.ack_req    = bus.m_hdr_ack_req;
    o.has_reth   = bus.m_hdr_has_reth;
    o.has_imm    = bus.m_hdr_has_imm;
    o.rem_addr   = bus.m_hdr_rem_addr;
    o.r_key      = bus.m_hdr_r_key;
    o.dma_length = bus.m_hdr_dma_length;
    o.imm        = bus.m_hdr_immediate_data;
    o.rem_qpn    = bus.m_hdr_rem_qpn;
    o.rem_ip     = bus.m_hdr_rem_ip_addr;
    return o;
  endfunction

  // Header sink: random back-pressure
  initial begin
    bus.m_hdr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.m_hdr_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_stall = 0;
    end else begin
      cur_hdr = observe();
      if (prev_stall) begin
        check("hdr_held_valid", bus.m_hdr_valid, 1);
        check("hdr_stable", 64'(cur_hdr != prev_hdr), 0);
      end
      prev_stall = bus.m_hdr_valid && !bus.m_hdr_ready;
      prev_hdr   = cur_hdr;
      if (bus.m_hdr_valid && bus.m_hdr_ready) begin
        hdr_seen++;
        if (exp_q.size() == 0) check("hdr_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("opcode", cur_hdr.opcode, mon_e.opcode);
          check("psn", cur_hdr.psn, mon_e.psn);
          check("payload", cur_hdr.payload, mon_e.payload);
          check("flags_last_ack_reth_imm",
                {cur_hdr.last, cur_hdr.ack_req, cur_hdr.has_reth, cur_hdr.has_imm},
                {mon_e.last, mon_e.ack_req, mon_e.has_reth, mon_e.has_imm});
          check("reth_addr", cur_hdr.rem_addr, mon_e.rem_addr);
          check("reth_rkey_len", {cur_hdr.r_key, cur_hdr.dma_length}, {mon_e.r_key, mon_e.dma_length});
          if (mon_e.has_imm) check("imm_data", cur_hdr.imm, mon_e.imm);
          check("qpn_ip", {cur_hdr.rem_qpn, cur_hdr.rem_ip}, {mon_e.rem_qpn, mon_e.rem_ip});
        end
      end
      if (bus.m_psn_upd_valid) begin
        if (exp_upd_q.size() == 0) check("psn_upd_unexpected", 1, 0);
        else begin
          mon_u = exp_upd_q.pop_front();
          check("psn_upd", {bus.m_psn_upd_loc_qpn, bus.m_psn_upd_next_psn}, mon_u);
          check("psn_upd_after_hdrs", 64'(exp_q.size()), 0);
        end
        busy = 0;
      end else if (busy) begin
        check("meta_ready_busy", bus.s_dma_meta_ready, 0);
      end
    end
  end

  // Driver: present one request, wait for accept, register it with the model
  task automatic send_req(input logic is_send, input logic imm, input logic [31:0] len,
                          input logic [2:0] code, input logic [23:0] psn0);
    logic [23:0] rqpn, lqpn;
    logic [31:0] rkey, ip, imm_data;
    logic [63:0] addr;
    int t;
    rqpn = 24'($urandom); lqpn = 24'($urandom);
    rkey = $urandom; ip = $urandom; imm_data = $urandom;
    addr = {$urandom, $urandom};
    t = 0;
    @(negedge clk);
    while (!bus.s_dma_meta_ready) begin
      @(negedge clk);
      t++;
      if (t > 3000) begin
        check("meta_ready_timeout", 0, 1);
        return;
      end
    end
    bus.s_dma_length     = len;
    bus.s_rem_qpn        = rqpn;
    bus.s_loc_qpn        = lqpn;
    bus.s_rem_psn        = psn0;
    bus.s_r_key          = rkey;
    bus.s_rem_ip_addr    = ip;
    bus.s_rem_addr       = addr;
    bus.s_is_immediate   = imm;
    bus.s_immediate_data = imm_data;
    bus.s_transfer_type  = is_send;
    cfg_pmtu             = code;
    bus.s_dma_meta_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.s_dma_meta_valid = 1'b0;
    // Scramble inputs after accept: the DUT must work from its latched copy
    bus.s_dma_length     = $urandom;
    bus.s_rem_qpn        = 24'($urandom);
    bus.s_rem_psn        = 24'($urandom);
    bus.s_r_key          = $urandom;
    bus.s_rem_ip_addr    = $urandom;
    bus.s_rem_addr       = {$urandom, $urandom};
    bus.s_is_immediate   = 1'($urandom);
    bus.s_immediate_data = $urandom;
    bus.s_transfer_type  = 1'($urandom);
    cfg_pmtu             = 3'($urandom);
    busy = 1;
    model_request(is_send, imm, len, code, psn0, rqpn, lqpn, rkey, ip, imm_data, addr);
    @(negedge clk);
    check("hdr_latency", bus.m_hdr_valid, 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 || exp_upd_q.size() != 0) begin
      @(negedge clk);
      #1;
      t++;
      if (t > 5000) begin
        check("drain_timeout", 64'(exp_q.size() + exp_upd_q.size()), 0);
        exp_q.delete();
        exp_upd_q.delete();
        busy = 0;
        break;
      end
    end
  endtask

  initial begin
    int target;
    int t;
    rst = 1'b1;
    cfg_pmtu = 3'd0;
    bus.s_dma_meta_valid = 1'b0;
    bus.s_dma_length = '0; bus.s_rem_qpn = '0; bus.s_loc_qpn = '0; bus.s_rem_psn = '0;
    bus.s_r_key = '0; bus.s_rem_ip_addr = '0; bus.s_rem_addr = '0;
    bus.s_is_immediate = 1'b0; bus.s_immediate_data = '0; bus.s_transfer_type = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hdr_valid", bus.m_hdr_valid, 0);
    check("rst_meta_ready", bus.s_dma_meta_ready, 0);
    check("rst_psn_upd", bus.m_psn_upd_valid, 0);
    check("rst_hdr_data", {bus.m_hdr_opcode, bus.m_hdr_psn, bus.m_hdr_payload_length}, 0);
    check("rst_dbg_state", dbg_state, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_low", bus.s_dma_meta_ready, 0);
    @(negedge clk);
    check("idle_ready_high", bus.s_dma_meta_ready, 1);
    mon_en = 1;

    // Directed cases
    ready_pct = 100;
    send_req(1'b0, 1'b0, 32'd4096, 3'd3, 24'h000010); wait_drain();
    send_req(1'b1, 1'b1, 32'd100,  3'd1, 24'h123456); wait_drain();
    send_req(1'b0, 1'b0, 32'd0,    3'd4, 24'h000777); wait_drain();
    send_req(1'b0, 1'b0, 32'd600,  3'd1, 24'hFFFFFF); wait_drain();
    send_req(1'b0, 1'b1, 32'd1300, 3'd7, 24'h000020); wait_drain();
    ready_pct = 30;
    send_req(1'b0, 1'b0, 32'd3000, 3'd5, 24'h000200); wait_drain();
    send_req(1'b1, 1'b1, 32'd2500, 3'd2, 24'hFFFFFE); wait_drain();

    // Reset in the middle of a four-packet request
    ready_pct = 100;
    target = hdr_seen + 2;
    send_req(1'b0, 1'b0, 32'd4096, 3'd3, 24'h000100);
    t = 0;
    while (hdr_seen < target && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("mid_rst_two_hdrs", 64'(hdr_seen >= target), 1);
    rst = 1'b1;
    mon_en = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_upd_q.delete();
    busy = 0;
    @(negedge clk);
    check("mid_rst_hdr_valid", bus.m_hdr_valid, 0);
    check("mid_rst_psn_upd", bus.m_psn_upd_valid, 0);
    check("mid_rst_hdr_data", {bus.m_hdr_opcode, bus.m_hdr_psn, bus.m_hdr_payload_length}, 0);
    check("mid_rst_state", dbg_state, 0);
    mon_en = 1;
    repeat (10) @(negedge clk);
    send_req(1'b1, 1'b0, 32'd700, 3'd2, 24'h000300); wait_drain();

    // Randomized requests
    for (int i = 0; i < 25; i++) begin
      logic [31:0] len;
      logic [23:0] psn0;
      case ($urandom_range(0, 3))
        0:       len = 32'($urandom_range(0, 1));
        1:       len = 32'($urandom_range(1, 300));
        2:       len = 32'($urandom_range(1, 9000));
        default: len = 32'(256 * $urandom_range(1, 16));
      endcase
      psn0 = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3)) : 24'($urandom);
      ready_pct = $urandom_range(20, 100);
      send_req(1'($urandom), 1'($urandom), len, 3'($urandom_range(0, 7)), psn0);
      wait_drain();
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
